regfile_sb: RTL and testbench

- Parametrised integer register file for the pipelined RISC-V core: 2 combinational read ports, 1 synchronous write port.
- Optional write-to-read bypass.
- Integrated per-register scoreboard: issue marks a destination pending; writeback clears it. The hazard unit consumes the result.
- Replaces the fixed 32x32 file. Register 0 stays hard-wired to zero.

---
 rtl/regfile_sb.sv | 92 +++++++++
 tb/tb_regfile_sb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one synchronous write port,
// optional write-to-read bypass and a per-register pending scoreboard for hazard detection.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    output logic [XLEN-1:0] busa,
    output logic [XLEN-1:0] busb,
    input  logic [AW-1:0]   rw,
    input  logic [XLEN-1:0] busw,
    input  logic            we,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            pend_a,
    output logic            pend_b,
    output logic [AW:0]     pend_cnt
);

    localparam int NREG = 1 << AW;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            wr_en;
    logic            iss_en;
    logic            hit_a;
    logic            hit_b;

    // Register 0 never takes a write or an issue, so both enables exclude it here.
    assign wr_en  = we && (rw != '0);
    assign iss_en = iss_valid && (iss_rd != '0);

    // Issue is applied after writeback so a same-register collision leaves the bit set.
    always_comb begin
        sb_next = sb;
        if (wr_en) begin
            sb_next[rw] = 1'b0;
        end
        if (iss_en) begin
            sb_next[iss_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            sb <= '0;
        end else begin
            if (wr_en) begin
                regs[rw] <= busw;
            end
            sb <= sb_next;
        end
    end

    // Bypass hits only on a live writeback to a nonzero address.
    assign hit_a = (BYPASS != 0) && wr_en && (rw == ra);
    assign hit_b = (BYPASS != 0) && wr_en && (rw == rb);

    always_comb begin
        busa = '0;
        if (ra != '0) begin
            busa = hit_a ? busw : regs[ra];
        end
    end

    always_comb begin
        busb = '0;
        if (rb != '0) begin
            busb = hit_b ? busw : regs[rb];
        end
    end

    assign pend_a = sb[ra] && !hit_a;
    assign pend_b = sb[rb] && !hit_b;

    always_comb begin
        pend_cnt = '0;
        for (int i = 1; i < NREG; i++) begin
            pend_cnt = pend_cnt + (AW + 1)'(sb[i]);
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing and one non-bypassing instance share stimulus,
// and each scenario task checks hand-computed expectations inline.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst;
    logic [AW-1:0]   ra, rb, rw, iss_rd;
    logic [XLEN-1:0] busw;
    logic            we, iss_valid;
    logic [XLEN-1:0] busa, busb, busa_nb, busb_nb;
    logic            pend_a, pend_b, pend_a_nb, pend_b_nb;
    logic [AW:0]     pend_cnt, pend_cnt_nb;

    int n_checks;
    int n_fail;

    regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .busa(busa), .busb(busb),
        .rw(rw), .busw(busw), .we(we), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .pend_a(pend_a), .pend_b(pend_b), .pend_cnt(pend_cnt)
    );

    regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .busa(busa_nb), .busb(busb_nb),
        .rw(rw), .busw(busw), .we(we), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .pend_a(pend_a_nb), .pend_b(pend_b_nb), .pend_cnt(pend_cnt_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        iss_valid = 1'b0;
        rw = '0;
        iss_rd = '0;
        busw = '0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (busa !== 32'h0 || busb !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got busa=%h busb=%h expected 0/0", busa, busb);
        end
        n_checks++;
        if (pend_a !== 1'b0 || pend_b !== 1'b0 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_pend: got %b %b cnt=%0d expected 0 0 0", pend_a, pend_b, pend_cnt);
        end
        tick();
        rst = 1'b0;
        // write reg5 and issue rd7 in one edge
        we = 1'b1; rw = 5'd5; busw = 32'h1234; iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        idle();
        ra = 5'd5; rb = 5'd7;
        #1;
        n_checks++;
        if (busa !== 32'h1234 || pend_b !== 1'b1 || pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL pre_reset_state: got busa=%h pend_b=%b cnt=%0d expected 1234 1 1",
                     busa, pend_b, pend_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        ra = 5'd5;
        #0;
        n_checks++;
        if (busa !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_busa: got %h expected 0", busa);
        end
        ra = 5'd7;
        #1;
        n_checks++;
        if (pend_a !== 1'b0 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL async_reset_pend: got pend_a=%b cnt=%0d expected 0 0", pend_a, pend_cnt);
        end
        // writes and issues held across an edge during reset must be ignored
        we = 1'b1; rw = 5'd5; busw = 32'hCAFE; iss_valid = 1'b1; iss_rd = 5'd8;
        tick();
        idle();
        rst = 1'b0;
        ra = 5'd5; rb = 5'd8;
        #1;
        n_checks++;
        if (busa !== 32'h0 || pend_b !== 1'b0 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ignores_ops: got busa=%h pend_b=%b cnt=%0d expected 0 0 0",
                     busa, pend_b, pend_cnt);
        end
    endtask

    task automatic test_x0();
        tick();
        we = 1'b1; rw = 5'd0; busw = 32'hDEADBEEF; iss_valid = 1'b1; iss_rd = 5'd0;
        ra = 5'd0; rb = 5'd0;
        #1;
        n_checks++;
        if (busa !== 32'h0 || busb !== 32'h0 || busa_nb !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_same_cycle: got busa=%h busb=%h busa_nb=%h expected 0", busa, busb, busa_nb);
        end
        n_checks++;
        if (pend_a !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_pend_same: got %b expected 0", pend_a);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busa !== 32'h0 || pend_a !== 1'b0 || pend_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL x0_next_cycle: got busa=%h pend_a=%b cnt=%0d expected 0 0 0",
                     busa, pend_a, pend_cnt);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; rw = 5'd3; busw = 32'h11;
        tick();
        idle();
        iss_valid = 1'b1; iss_rd = 5'd3; ra = 5'd3;
        #1;
        n_checks++;
        if (pend_a !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_not_early: got pend_a=%b expected 0", pend_a);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (pend_cnt !== 6'd1 || pend_a !== 1'b1 || busa !== 32'h11) begin
            n_fail++;
            $display("FAIL bypass_setup: got cnt=%0d pend_a=%b busa=%h expected 1 1 11",
                     pend_cnt, pend_a, busa);
        end
        we = 1'b1; rw = 5'd3; busw = 32'h22;
        #1;
        n_checks++;
        if (busa !== 32'h22 || pend_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_fwd: got busa=%h pend_a=%b expected 22 0", busa, pend_a);
        end
        n_checks++;
        if (busa_nb !== 32'h11 || pend_a_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL nobypass_read: got busa=%h pend_a=%b expected 11 1", busa_nb, pend_a_nb);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busa !== 32'h22 || busa_nb !== 32'h22 || pend_cnt !== 6'd0 || pend_cnt_nb !== 6'd0) begin
            n_fail++;
            $display("FAIL bypass_after: got busa=%h busa_nb=%h cnt=%0d cnt_nb=%0d expected 22 22 0 0",
                     busa, busa_nb, pend_cnt, pend_cnt_nb);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd4;
        tick();
        n_checks++;
        if (pend_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL sb_cnt1: got %0d expected 1", pend_cnt);
        end
        iss_rd = 5'd9;
        tick();
        n_checks++;
        if (pend_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL sb_cnt2: got %0d expected 2", pend_cnt);
        end
        iss_rd = 5'd31;
        tick();
        n_checks++;
        if (pend_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL sb_cnt3: got %0d expected 3", pend_cnt);
        end
        idle();
        we = 1'b1; rw = 5'd9; busw = 32'h99;
        tick();
        idle();
        ra = 5'd4; rb = 5'd9;
        #1;
        n_checks++;
        if (pend_cnt !== 6'd2 || pend_b !== 1'b0 || pend_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_writeback: got cnt=%0d pend_b=%b pend_a=%b expected 2 0 1",
                     pend_cnt, pend_b, pend_a);
        end
        ra = 5'd31;
        #1;
        n_checks++;
        if (pend_a !== 1'b1 || pend_a_nb !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_top_reg: got pend_a=%b pend_a_nb=%b expected 1 1", pend_a, pend_a_nb);
        end
    endtask

    task automatic test_collision();
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        n_checks++;
        if (pend_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL coll_setup: got %0d expected 3", pend_cnt);
        end
        we = 1'b1; rw = 5'd6; busw = 32'h55;
        tick();
        idle();
        ra = 5'd6;
        #1;
        n_checks++;
        if (busa !== 32'h55 || pend_a !== 1'b1 || pend_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL collision: got busa=%h pend_a=%b cnt=%0d expected 55 1 3",
                     busa, pend_a, pend_cnt);
        end
        // different registers in one edge; plus a duplicate issue next
        we = 1'b1; rw = 5'd4; busw = 32'h44; iss_valid = 1'b1; iss_rd = 5'd10;
        tick();
        idle();
        ra = 5'd4; rb = 5'd10;
        #1;
        n_checks++;
        if (pend_a !== 1'b0 || pend_b !== 1'b1 || pend_cnt !== 6'd3 || busa !== 32'h44) begin
            n_fail++;
            $display("FAIL split_write_issue: got pend_a=%b pend_b=%b cnt=%0d busa=%h expected 0 1 3 44",
                     pend_a, pend_b, pend_cnt, busa);
        end
        iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        idle();
        ra = 5'd6;
        #1;
        n_checks++;
        if (pend_a !== 1'b1 || pend_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL dup_issue: got pend_a=%b cnt=%0d expected 1 3", pend_a, pend_cnt);
        end
    endtask

    task automatic test_dual_read();
        we = 1'b1; rw = 5'd1; busw = 32'hA;
        tick();
        rw = 5'd2; busw = 32'hB;
        tick();
        idle();
        ra = 5'd1; rb = 5'd2;
        #1;
        n_checks++;
        if (busa !== 32'hA || busb !== 32'hB) begin
            n_fail++;
            $display("FAIL dual_read: got busa=%h busb=%h expected a b", busa, busb);
        end
        n_checks++;
        if (pend_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL nonpending_write: got cnt=%0d expected 3", pend_cnt);
        end
        ra = 5'd2;
        #1;
        n_checks++;
        if (busa !== 32'hB || busb !== 32'hB) begin
            n_fail++;
            $display("FAIL same_addr_read: got busa=%h busb=%h expected b b", busa, busb);
        end
        ra = 5'd1;
        we = 1'b1; rw = 5'd2; busw = 32'hC;
        #1;
        n_checks++;
        if (busb !== 32'hC || busa !== 32'hA || busb_nb !== 32'hB) begin
            n_fail++;
            $display("FAIL bypass_port_b: got busb=%h busa=%h busb_nb=%h expected c a b",
                     busb, busa, busb_nb);
        end
        tick();
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        ra = '0;
        rb = '0;
        idle();
        test_reset();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_dual_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
